// File: rtl/seq_drive_pkg.sv
// seq_drive_pkg: shared FSM states, default width and counter-width helper for seq_drive_ctrl.
package seq_drive_pkg;
    localparam int DEF_WIDTH = 8;
    typedef enum logic [2:0] {IDLE, CLR, SHIFT, DRAIN, DONE} state_t;
    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction
endpackage

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: loadable LSB-first shift register with bit index and last-bit flag.
//   i_load/i_data/i_len load a pattern; i_shift advances one bit.
//   o_bit is the current bit, o_idx the current bit index.
//   o_first/o_last flag bit 0 and bit len-1; o_empty flags len==0.
module seq_bit_serializer
    import seq_drive_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic [CNT_W-1:0] i_len,
    input  logic             i_shift,
    output logic             o_bit,
    output logic [CNT_W-1:0] o_idx,
    output logic             o_first,
    output logic             o_last,
    output logic             o_empty
);
    logic [WIDTH-1:0] r_data;
    logic [CNT_W-1:0] r_idx;
    logic [CNT_W-1:0] r_len;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
            r_idx  <= '0;
            r_len  <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_idx  <= '0;
            r_len  <= i_len;
        end else if (i_shift) begin
            r_data <= r_data >> 1;
            r_idx  <= r_idx + CNT_W'(1);
        end
    end
    assign o_bit   = r_data[0];
    assign o_idx   = r_idx;
    assign o_first = r_idx == '0;
    assign o_last  = r_idx == r_len - CNT_W'(1);
    assign o_empty = r_len == '0;
endmodule

// File: rtl/seq_drive_ctrl.sv
// seq_drive_ctrl: shifts a pattern into a two-flop serial circuit and counts cycles with y=1.
//   Handshake: in_valid/in_ready with in_data (LSB first) and in_len (clamped to WIDTH).
//   Driven circuit: dut_rst, dut_x out; dut_y in.
//   Status: busy, done (one-cycle pulse), hit_count.
//   Define SEQ_TRACE_CAPTURE_EN to add y_trace (sample k stored in bit k).
module seq_drive_ctrl
    import seq_drive_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] in_len,
    output logic             dut_rst,
    output logic             dut_x,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
`ifdef SEQ_TRACE_CAPTURE_EN
    output logic [WIDTH-1:0] y_trace,
`endif
    output logic [CNT_W-1:0] hit_count
);
    state_t           r_state, w_next;
    logic             w_load, w_shift, w_sample;
    logic             w_bit, w_first, w_last, w_empty;
    logic [CNT_W-1:0] w_idx, w_len, r_hits;
    assign w_len = (in_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : in_len;
    seq_bit_serializer #(.WIDTH(WIDTH)) u_ser (
        .clk     (clk),
        .reset   (reset),
        .i_load  (w_load),
        .i_data  (in_data),
        .i_len   (w_len),
        .i_shift (w_shift),
        .o_bit   (w_bit),
        .o_idx   (w_idx),
        .o_first (w_first),
        .o_last  (w_last),
        .o_empty (w_empty)
    );
    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end
    // The first SHIFT cycle still shows the cleared circuit, so it is not sampled.
    always_comb begin
        w_next   = r_state;
        w_load   = 1'b0;
        w_shift  = 1'b0;
        w_sample = 1'b0;
        case (r_state)
            IDLE:  if (in_valid) begin
                w_load = 1'b1;
                w_next = CLR;
            end
            CLR:   w_next = w_empty ? DONE : SHIFT;
            SHIFT: begin
                w_shift  = 1'b1;
                w_sample = !w_first;
                w_next   = w_last ? DRAIN : SHIFT;
            end
            DRAIN: begin
                w_sample = 1'b1;
                w_next   = DONE;
            end
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset || w_load)                                r_hits <= '0;
        else if (w_sample && dut_y && r_hits != CNT_W'(WIDTH)) r_hits <= r_hits + CNT_W'(1);
    end
`ifdef SEQ_TRACE_CAPTURE_EN
    logic [WIDTH-1:0] r_trace;
    // The index has already advanced past the sampled bit, so sample k sits at w_idx-1.
    always_ff @(posedge clk) begin
        if (reset || w_load)      r_trace <= '0;
        else if (w_sample && dut_y) r_trace <= r_trace | (WIDTH'(1) << (w_idx - CNT_W'(1)));
    end
    assign y_trace = r_trace;
`else
    logic w_unused;
    assign w_unused = ^w_idx;
`endif
    assign hit_count = r_hits;
    assign in_ready  = r_state == IDLE;
    assign busy      = r_state == CLR || r_state == SHIFT || r_state == DRAIN;
    assign done      = r_state == DONE;
    assign dut_x     = r_state == SHIFT && w_bit;
    assign dut_rst   = reset || r_state == CLR;
endmodule
